shiftreg_seq_ctrl: RTL

- Sequencing controller for the deep byte-wide shift-register delay chain (DEPTH stages, shift-enable, data in/out).
- Owns the chain's shift enable. Tracks how many valid bytes the chain holds.
- Converts the raw chain into a valid/ready stream: bytes come out in order after DEPTH accepted shifts.
- A flush command drains the remaining valid bytes by shifting in zero padding.

---
 rtl/shiftreg_ctrl_pkg.sv | 15 +
 rtl/shiftreg_occ_cnt.sv | 35 +++
 rtl/shiftreg_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/shiftreg_ctrl_pkg.sv
// Shared definitions for the shift-register sequencing controller.
// State encoding and default geometry of the controlled delay chain.
package shiftreg_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        ALIGN = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_DEPTH = 2000;
    localparam int DEF_W     = 8;

endpackage

// File: rtl/shiftreg_occ_cnt.sv
// Up/down/load occupancy counter with decode flags.
// Load wins over inc/dec; simultaneous inc and dec cancel.
module shiftreg_occ_cnt #(
    parameter int CW  = 12,
    parameter int MAX = 2000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          is_zero,
    output logic          is_one,
    output logic          is_full_m1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            count <= count + CW'(1);
        end else if (dec && !inc) begin
            count <= count - CW'(1);
        end
    end

    assign is_zero    = (count == '0);
    assign is_one     = (count == CW'(1));
    assign is_full_m1 = (count == CW'(MAX - 1));

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Sequencing controller turning a deep shift chain into a valid/ready stream.
// Tracks chain occupancy and drains it on flush by shifting in zero padding.
module shiftreg_seq_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_W,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          sr_shift_en,
    output logic [W-1:0]  sr_data_in,
    input  logic [W-1:0]  sr_data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] fill_count
);

    state_t        state;
    state_t        state_nxt;

    logic          f_inc;
    logic          f_dec;
    logic          f_zero;
    logic          f_one;
    logic          f_full_m1;

    logic          p_load;
    logic          p_dec;
    logic [CW-1:0] p_val;
    logic [CW-1:0] p_count;
    logic          p_zero;
    logic          p_one;
    logic          p_full_m1;
    logic          unused_pad_flags;

    shiftreg_occ_cnt #(
        .CW  (CW),
        .MAX (DEPTH)
    ) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (f_inc),
        .dec        (f_dec),
        .load       (1'b0),
        .load_val   ('0),
        .count      (fill_count),
        .is_zero    (f_zero),
        .is_one     (f_one),
        .is_full_m1 (f_full_m1)
    );

    shiftreg_occ_cnt #(
        .CW  (CW),
        .MAX (DEPTH)
    ) u_pad (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (1'b0),
        .dec        (p_dec),
        .load       (p_load),
        .load_val   (p_val),
        .count      (p_count),
        .is_zero    (p_zero),
        .is_one     (p_one),
        .is_full_m1 (p_full_m1)
    );

    assign unused_pad_flags = &{1'b0, p_zero, p_full_m1, p_count};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        sr_shift_en = 1'b0;
        sr_data_in  = '0;
        f_inc       = 1'b0;
        f_dec       = 1'b0;
        p_load      = 1'b0;
        p_dec       = 1'b0;
        p_val       = CW'(DEPTH) - fill_count - CW'(in_valid);
        unique case (state)
            FILL: begin
                in_ready    = 1'b1;
                sr_shift_en = in_valid;
                sr_data_in  = in_data;
                f_inc       = in_valid;
                if (in_valid && f_full_m1) begin
                    state_nxt = RUN;
                end
                // flush acts on the count after this cycle's accept
                if (flush_req) begin
                    if (in_valid && f_full_m1) begin
                        state_nxt = DRAIN;
                    end else if (in_valid || !f_zero) begin
                        state_nxt = ALIGN;
                        p_load    = 1'b1;
                    end
                end
            end
            RUN: begin
                out_valid   = 1'b1;
                in_ready    = out_ready;
                sr_shift_en = in_valid & out_ready;
                sr_data_in  = in_data;
                if (flush_req) begin
                    state_nxt = DRAIN;
                end
            end
            ALIGN: begin
                sr_shift_en = 1'b1;
                p_dec       = 1'b1;
                if (p_one) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid   = 1'b1;
                sr_shift_en = out_ready;
                f_dec       = out_ready;
                if (out_ready && f_one) begin
                    state_nxt = FILL;
                end
            end
        endcase
    end

    assign flush_busy = (state == ALIGN) || (state == DRAIN);
    assign out_data   = sr_data_out;

endmodule
